// File: rtl/friscv_perf_pkg.sv
// Shared definitions for the performance-counter reader: FSM state encoding,
// per-bus counter offsets and the layout of the optional header word.
package friscv_perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } perf_state_e;

  // Counter order inside one bus slice of the perfs vector.
  localparam int ACTIVE_IDX  = 0;
  localparam int SLEEP_IDX   = 1;
  localparam int STALL_IDX   = 2;
  localparam int CNT_PER_BUS = 3;

  // Header word fields: [15:8] bus count, [7:0] counter-word count.
  localparam int HDR_NB_BUS_LSB = 8;
  localparam int HDR_NB_CNT_LSB = 0;
  localparam int HDR_FIELD_W    = 8;

  function automatic logic [15:0] hdr_word(input int nb_bus);
    logic [15:0] nb_bus_f;
    logic [15:0] nb_cnt_f;
    nb_bus_f = 16'(nb_bus) & 16'((1 << HDR_FIELD_W) - 1);
    nb_cnt_f = 16'(CNT_PER_BUS * nb_bus) & 16'((1 << HDR_FIELD_W) - 1);
    return (nb_bus_f << HDR_NB_BUS_LSB) | (nb_cnt_f << HDR_NB_CNT_LSB);
  endfunction

endpackage

// File: rtl/friscv_perf_reader.sv
// Snapshot-and-stream reader for bus performance counters.
// On dump_req in IDLE the whole perfs vector is frozen into a snapshot
// register (perf_clr pulses the same cycle) and streamed word by word:
// bus 0 active/sleep/stall, then bus 1, and so on.
// Optional macro FRISCV_PERF_HEADER_EN prepends a header word
// {NB_BUS[7:0], (3*NB_BUS)[7:0]} in the low 16 bits.
// Handshake: a word transfers on a rising edge where out_valid && out_ready;
// once out_valid is high, out_valid/out_data/out_last hold until that transfer.
module friscv_perf_reader
  import friscv_perf_pkg::*;
#(
  parameter int REG_W  = 32,
  parameter int NB_BUS = 1
) (
  input  logic                        aclk,
  input  logic                        srst,
  input  logic [NB_BUS*REG_W*3-1:0]   perfs,
  input  logic                        dump_req,
  output logic                        perf_clr,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [REG_W-1:0]            out_data,
  output logic                        out_last,
  output logic                        done,
  output logic [1:0]                  dbg_state
);

  localparam int NB_CNT = CNT_PER_BUS * NB_BUS;
`ifdef FRISCV_PERF_HEADER_EN
  localparam int NB_WORDS = NB_CNT + 1;
  localparam logic [REG_W-1:0] HDR_WORD = REG_W'(hdr_word(NB_BUS));
`else
  localparam int NB_WORDS = NB_CNT;
`endif
  localparam int IDX_W = $clog2(NB_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_WORDS - 1);

  perf_state_e                 state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NB_BUS*REG_W*3-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]            cnt_sel;
  logic [REG_W-1:0]            word_sel;
  logic                        handshake;

  assign handshake = out_valid && out_ready;
  assign dbg_state = state_q;

  // State register; reset wins over every other event.
  always_ff @(posedge aclk) begin
    if (srst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: a request is only taken in IDLE, so requests in SEND/DONE drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dump_req) state_d = SEND;
      SEND:    if (handshake && out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; perf_clr marks the snapshot cycle and is masked by reset.
  always_comb begin
    perf_clr  = (state_q == IDLE) && dump_req && !srst;
    out_valid = (state_q == SEND);
    out_last  = out_valid && (idx_q == LAST_IDX);
    done      = (state_q == DONE);
    busy      = perf_clr || (state_q != IDLE);
  end

  // Snapshot and word index next values: index restarts at every snapshot.
  always_comb begin
    snap_d = snap_q;
    idx_d  = idx_q;
    if (perf_clr) begin
      snap_d = perfs;
      idx_d  = '0;
    end else if (handshake) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Snapshot register and word index.
  always_ff @(posedge aclk) begin
    if (srst) begin
      snap_q <= '0;
      idx_q  <= '0;
    end else begin
      snap_q <= snap_d;
      idx_q  <= idx_d;
    end
  end

  // Word select: counter index clamped so the part-select never leaves the snapshot.
  always_comb begin
`ifdef FRISCV_PERF_HEADER_EN
    cnt_sel = idx_q - 1'b1;
`else
    cnt_sel = idx_q;
`endif
    if (int'(cnt_sel) >= NB_CNT) cnt_sel = '0;
    word_sel = snap_q[int'(cnt_sel)*REG_W +: REG_W];
`ifdef FRISCV_PERF_HEADER_EN
    if (idx_q == '0) word_sel = HDR_WORD;
`endif
    out_data = '0;
    if (state_q == SEND) out_data = word_sel;
  end

endmodule
